// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed common-cathode seven-segment driver: double-buffered digit
// codes, BCD/hex decode, per-digit decimal points and leading-zero suppression.
module seven_segment_scan_driver #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 1000,
  parameter int HEX_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     sel_out,
  output logic                  frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]          pcnt;
  logic [IW-1:0]          idx;
  logic                   tick;
  logic                   wrap;
  logic                   commit;

  logic [4*DIGITS-1:0]    pend_digits;
  logic [DIGITS-1:0]      pend_dp;
  logic                   pend_lz;
  logic                   pend_v;
  logic [4*DIGITS-1:0]    disp_digits;
  logic [DIGITS-1:0]      disp_dp;
  logic                   disp_lz;

  logic [3:0]             cur_code;
  logic                   upper_nz;
  logic                   lz_blank;
  logic [7:0]             seg_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    if (HEX_EN == 0 && code > 4'd9) s = 7'h00;
    return s;
  endfunction

  assign tick   = enable && (pcnt == P_LAST);
  assign wrap   = tick && (idx == I_LAST);
  // Disabled cycles commit continuously so re-enable starts on fresh data.
  assign commit = wrap || !enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (!enable) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= wrap ? '0 : idx + IW'(1);
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // A load coinciding with a commit bypasses pending and lands in the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_lz     <= 1'b0;
      pend_v      <= 1'b0;
      disp_digits <= '0;
      disp_dp     <= '0;
      disp_lz     <= 1'b0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_lz     <= blank_lz;
        pend_v      <= !commit;
      end else if (commit) begin
        pend_v      <= 1'b0;
      end
      if (commit) begin
        if (load) begin
          disp_digits <= digits_in;
          disp_dp     <= dp_in;
          disp_lz     <= blank_lz;
        end else if (pend_v) begin
          disp_digits <= pend_digits;
          disp_dp     <= pend_dp;
          disp_lz     <= pend_lz;
        end
      end
    end
  end

  always_comb begin
    cur_code = 4'd0;
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == int'(idx)) cur_code = disp_digits[4*i +: 4];
      if (i >= int'(idx) && disp_digits[4*i +: 4] != 4'd0) upper_nz = 1'b1;
    end
    lz_blank = disp_lz && (idx != '0) && !upper_nz;
    seg_next = {disp_dp[idx], lz_blank ? 7'h00 : decode(cur_code)};
  end

  // Output register stage: segments/select lag idx by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out    <= 8'h00;
      sel_out    <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (enable) begin
        seg_out <= seg_next;
        sel_out <= ~(DIGITS'(1) << idx);
      end else begin
        seg_out <= 8'h00;
        sel_out <= '1;
      end
    end
  end

endmodule
